// File: rtl/soc_ctrl_cmd_engine.sv
// ----------------------------------------------------------------------------
// soc_ctrl_cmd_engine
//
// Purpose:
//   Decodes the host UART byte stream into SoC clock-enable, reset and
//   UART-routing controls. Single-byte opcodes act immediately. RUN_N (0x08)
//   and RESET_N (0x09) take ARG_BYTES little-endian argument bytes. STATUS
//   (0x0A) returns one status byte on a valid/ready channel. Every received
//   byte is decoded, including repeats of the previous byte.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high
//   rx_valid     in   1  one-cycle strobe, rx_data holds a received byte
//   rx_data      in   8  received byte
//   tx_ready     in   1  transmitter can accept a byte
//   tx_valid     out  1  response byte pending
//   tx_data      out  8  response byte
//   soc_clk_en   out  1  SoC clock gate enable
//   soc_reset    out  1  SoC reset, active-high
//   tx_sel_ctrl  out  1  1: host TX driven by controller echo path, 0: by SoC
//   rx_block     out  1  1: SoC UART RX forced low
//   busy         out  1  high while collecting arguments or holding a response
//   led_n        out  1  active-low reset indicator (~soc_reset)
//
// Optional build macro:
//   CMD_ACK_EN - every completed command other than STATUS also returns an
//                acknowledge byte (0xA0 | opcode[3:0]); an invalid opcode or
//                an argument timeout returns 0xEE. If a response is already
//                pending, the acknowledge is dropped and err is set.
//
// FSM states:
//   state   | meaning
//   IDLE    | decode every received byte as an opcode
//   ARG     | collecting argument bytes for RUN_N / RESET_N
//   RESP    | response byte offered on tx, waiting for tx_ready
// ----------------------------------------------------------------------------
module soc_ctrl_cmd_engine #(
    parameter int RESET_CYCLES = 50,
    parameter int ARG_BYTES    = 3,
    parameter int ARG_TIMEOUT  = 270000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       soc_clk_en,
    output logic       soc_reset,
    output logic       tx_sel_ctrl,
    output logic       rx_block,
    output logic       busy,
    output logic       led_n
);

    localparam int CNT_W = 8 * ARG_BYTES;
    localparam int IDX_W = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;
    localparam int TO_W  = $clog2(ARG_TIMEOUT + 1);

    localparam logic [7:0] OP_CLK_OFF   = 8'h00;
    localparam logic [7:0] OP_CLK_ON    = 8'h01;
    localparam logic [7:0] OP_RST_PULSE = 8'h02;
    localparam logic [7:0] OP_RST_CLR   = 8'h03;
    localparam logic [7:0] OP_TXSEL_SOC = 8'h04;
    localparam logic [7:0] OP_TXSEL_CTL = 8'h05;
    localparam logic [7:0] OP_RX_OPEN   = 8'h06;
    localparam logic [7:0] OP_RX_BLOCK  = 8'h07;
    localparam logic [7:0] OP_RUN_N     = 8'h08;
    localparam logic [7:0] OP_RESET_N   = 8'h09;
    localparam logic [7:0] OP_STATUS    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   arg_q, arg_d;
    logic [IDX_W-1:0]   arg_idx_q, arg_idx_d;
    logic               arg_op_q, arg_op_d;      // 0: RUN_N, 1: RESET_N
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic               clk_en_q, clk_en_d;
    logic               soc_reset_q, soc_reset_d;
    logic               tx_sel_q, tx_sel_d;
    logic               rx_block_q, rx_block_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               err_q, err_d;

    logic               exec_en;
    logic [7:0]         exec_op;
    logic [CNT_W-1:0]   exec_arg;
    logic [CNT_W-1:0]   arg_full;
    logic               run_active;
    logic [7:0]         status_byte;
`ifdef CMD_ACK_EN
    logic               resp_req;
    logic [7:0]         resp_byte;
    logic               exec_bad;
`endif

    assign run_active  = (run_cnt_q != '0);
    assign status_byte = {2'b00, err_q, run_active, rx_block_q, tx_sel_q,
                          soc_reset_q, clk_en_q};

    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        arg_idx_d   = arg_idx_q;
        arg_op_d    = arg_op_q;
        to_cnt_d    = to_cnt_q;
        run_cnt_d   = run_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        clk_en_d    = clk_en_q;
        tx_sel_d    = tx_sel_q;
        rx_block_d  = rx_block_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        exec_en     = 1'b0;
        exec_op     = 8'h00;
        exec_arg    = '0;
        arg_full    = arg_q;
`ifdef CMD_ACK_EN
        resp_req    = 1'b0;
        resp_byte   = 8'h00;
        exec_bad    = 1'b0;
`endif

        // Free-running counters step first; any opcode executed below
        // overrides them, so a cancel on the expiry cycle wins.
        if (run_cnt_q != '0) begin
            run_cnt_d = run_cnt_q - CNT_W'(1);
            if (run_cnt_q == CNT_W'(1)) begin
                clk_en_d = 1'b0;
            end
        end
        if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
        end

        for (int i = 0; i < ARG_BYTES; i++) begin
            if (arg_idx_q == IDX_W'(i)) begin
                arg_full[8*i +: 8] = rx_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_RUN_N, OP_RESET_N: begin
                            state_d   = ST_ARG;
                            arg_d     = '0;
                            arg_idx_d = '0;
                            arg_op_d  = rx_data[0];
                            to_cnt_d  = TO_W'(ARG_TIMEOUT - 1);
                        end
                        OP_STATUS: begin
                            state_d   = ST_RESP;
                            tx_data_d = status_byte;
                            err_d     = 1'b0;
                        end
                        default: begin
                            exec_en = 1'b1;
                            exec_op = rx_data;
                        end
                    endcase
                end
            end

            ST_ARG: begin
                if (rx_valid) begin
                    arg_d     = arg_full;
                    arg_idx_d = arg_idx_q + IDX_W'(1);
                    to_cnt_d  = TO_W'(ARG_TIMEOUT - 1);
                    if (arg_idx_q == IDX_W'(ARG_BYTES - 1)) begin
                        state_d  = ST_IDLE;
                        exec_en  = 1'b1;
                        exec_op  = arg_op_q ? OP_RESET_N : OP_RUN_N;
                        exec_arg = arg_full;
                    end
                end else if (to_cnt_q == '0) begin
                    // Abort: the partial argument is discarded.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
`ifdef CMD_ACK_EN
                    resp_req  = 1'b1;
                    resp_byte = 8'hEE;
`endif
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end

            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
                // Only single-byte opcodes are honoured while a response is held.
                if (rx_valid) begin
                    if (rx_data == OP_RUN_N || rx_data == OP_RESET_N ||
                        rx_data == OP_STATUS) begin
                        err_d = 1'b1;
                    end else begin
                        exec_en = 1'b1;
                        exec_op = rx_data;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (exec_en) begin
            case (exec_op)
                OP_CLK_OFF: begin
                    clk_en_d  = 1'b0;
                    run_cnt_d = '0;
                end
                OP_CLK_ON: begin
                    clk_en_d  = 1'b1;
                    run_cnt_d = '0;
                end
                OP_RST_PULSE: pulse_cnt_d = CNT_W'(RESET_CYCLES);
                OP_RST_CLR:   pulse_cnt_d = '0;
                OP_TXSEL_SOC: tx_sel_d    = 1'b0;
                OP_TXSEL_CTL: tx_sel_d    = 1'b1;
                OP_RX_OPEN:   rx_block_d  = 1'b0;
                OP_RX_BLOCK:  rx_block_d  = 1'b1;
                OP_RUN_N: begin
                    run_cnt_d = exec_arg;
                    clk_en_d  = (exec_arg != '0);
                end
                OP_RESET_N:   pulse_cnt_d = exec_arg;
                default: begin
                    err_d = 1'b1;
`ifdef CMD_ACK_EN
                    exec_bad = 1'b1;
`endif
                end
            endcase
        end

`ifdef CMD_ACK_EN
        if (exec_en) begin
            resp_req  = 1'b1;
            resp_byte = exec_bad ? 8'hEE : {4'hA, exec_op[3:0]};
        end
        if (resp_req) begin
            if (state_q == ST_RESP) begin
                err_d = 1'b1;
            end else begin
                state_d   = ST_RESP;
                tx_data_d = resp_byte;
            end
        end
`endif

        soc_reset_d = (pulse_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            arg_q       <= '0;
            arg_idx_q   <= '0;
            arg_op_q    <= 1'b0;
            to_cnt_q    <= '0;
            run_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            clk_en_q    <= 1'b1;
            soc_reset_q <= 1'b0;
            tx_sel_q    <= 1'b0;
            rx_block_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arg_q       <= arg_d;
            arg_idx_q   <= arg_idx_d;
            arg_op_q    <= arg_op_d;
            to_cnt_q    <= to_cnt_d;
            run_cnt_q   <= run_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            clk_en_q    <= clk_en_d;
            soc_reset_q <= soc_reset_d;
            tx_sel_q    <= tx_sel_d;
            rx_block_q  <= rx_block_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
        end
    end

    assign tx_valid    = (state_q == ST_RESP);
    assign tx_data     = tx_data_q;
    assign soc_clk_en  = clk_en_q;
    assign soc_reset   = soc_reset_q;
    assign tx_sel_ctrl = tx_sel_q;
    assign rx_block    = rx_block_q;
    assign busy        = (state_q != ST_IDLE);
    assign led_n       = ~soc_reset_q;

endmodule

// File: tb/tb_soc_ctrl_cmd_engine.sv
module tb_soc_ctrl_cmd_engine;

    localparam int ARG_TO = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       soc_clk_en;
    logic       soc_reset;
    logic       tx_sel_ctrl;
    logic       rx_block;
    logic       busy;
    logic       led_n;

    soc_ctrl_cmd_engine #(
        .RESET_CYCLES(50),
        .ARG_BYTES   (3),
        .ARG_TIMEOUT (ARG_TO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .soc_clk_en (soc_clk_en),
        .soc_reset  (soc_reset),
        .tx_sel_ctrl(tx_sel_ctrl),
        .rx_block   (rx_block),
        .busy       (busy),
        .led_n      (led_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb_q[$];

    // Independent model of controller state used to predict STATUS bytes.
    logic m_err = 1'b0, m_run = 1'b0, m_rxb = 1'b0, m_txs = 1'b0, m_rst = 1'b0, m_clk = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st_byte();
        return {2'b00, m_err, m_run, m_rxb, m_txs, m_rst, m_clk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Count consecutive samples with the selected signal high (0: soc_reset, 1: soc_clk_en).
    task automatic measure_high(input int sel, output int n);
        n = 0;
        while (((sel == 0) ? soc_reset : soc_clk_en) && n < 400) begin
            n++;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_clk_en"}, soc_clk_en, 1'b1);
        check({tag, "_soc_reset"}, soc_reset, 1'b0);
        check({tag, "_tx_sel"}, tx_sel_ctrl, 1'b0);
        check({tag, "_rx_block"}, rx_block, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_led_n"}, led_n, 1'b1);
    endtask

    // Response monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", tx_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("rst");

`ifndef CMD_ACK_EN
        // 1: reset pulses, repeat not filtered, restart mid-pulse
        send(8'h02);
        check("pulse_led_n", led_n, 1'b0);
        measure_high(0, n);
        check("pulse_len", n, 50);
        send(8'h02);
        measure_high(0, n);
        check("pulse_len_repeat", n, 50);
        send(8'h02);
        repeat (20) tick();
        send(8'h02);
        measure_high(0, n);
        check("pulse_len_restart", n, 50);
        check("pulse_led_after", led_n, 1'b1);

        // 2: counted runs
        send(8'h08); send(8'h10); send(8'h00); send(8'h00);
        measure_high(1, n);
        check("run_len_16", n, 16);
        send(8'h01);
        send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        check("run_zero", soc_clk_en, 1'b0);

        // 3: status held while tx_ready is low
        send(8'h00); m_clk = 1'b0;
        send(8'h07); m_rxb = 1'b1;
        send(8'h05); m_txs = 1'b1;
        sb_q.push_back(st_byte());
        send(8'h0A); m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_data", tx_data, 8'h0C);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("hs_valid_drop", tx_valid, 1'b0);

        // 4: argument timeout aborts with err, err clears on status
        send(8'h09);
        check("arg_busy", busy, 1'b1);
        send(8'h05);
        repeat (ARG_TO + 5) tick();
        check("to_busy", busy, 1'b0);
        check("to_soc_reset", soc_reset, 1'b0);
        m_err = 1'b1;
        sb_q.push_back(st_byte());
        send(8'h0A); m_err = 1'b0;
        tick();
        sb_q.push_back(st_byte());
        send(8'h0A);
        tick();

        // 5: long run, status mid-run, cancel
        send(8'h08); send(8'hFF); send(8'hFF); send(8'h00);
        m_clk = 1'b1; m_run = 1'b1;
        check("long_run_on", soc_clk_en, 1'b1);
        repeat (4) tick();
        sb_q.push_back(st_byte());
        send(8'h0A);
        tick();
        repeat (4) tick();
        send(8'h00); m_clk = 1'b0; m_run = 1'b0;
        check("cancel_clk_en", soc_clk_en, 1'b0);
        sb_q.push_back(st_byte());
        send(8'h0A);
        tick();

        // expiry and cancelling opcode on the same cycle: opcode wins
        send(8'h08); send(8'h03); send(8'h00); send(8'h00);
        tick(); tick();
        send(8'h01); m_clk = 1'b1;
        check("expiry_vs_cancel", soc_clk_en, 1'b1);
        repeat (3) tick();
        check("cancel_sticks", soc_clk_en, 1'b1);

        // bytes arriving while a response is held
        tx_ready = 1'b0;
        sb_q.push_back(st_byte());
        send(8'h0A);
        send(8'h06); m_rxb = 1'b0;
        check("resp_exec_rx_block", rx_block, 1'b0);
        send(8'h0A); m_err = 1'b1;
        check("resp_data_stable", tx_data, 8'h0D);
        check("resp_busy", busy, 1'b1);
        tx_ready = 1'b1;
        tick();
        check("resp_done", tx_valid, 1'b0);
        sb_q.push_back(st_byte());
        send(8'h0A); m_err = 1'b0;
        tick();

        // reset asserted while a response is pending
        tx_ready = 1'b0;
        send(8'h02);
        check("mid_pulse", soc_reset, 1'b1);
        send(8'h0A);
        check("mid_resp_valid", tx_valid, 1'b1);
`else
        // acknowledge mode
        tx_ready = 1'b1;
        sb_q.push_back(8'hA6);
        send(8'h06);
        tick();
        sb_q.push_back(8'hEE);
        send(8'h3C);
        tick();
        check("ack_idle", tx_valid, 1'b0);
        tx_ready = 1'b0;
        send(8'h07);
        check("ack_valid", tx_valid, 1'b1);
        check("ack_data", tx_data, 8'hA7);
        check("ack_rx_block", rx_block, 1'b1);
`endif
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
